// File: rtl/wb_arbiter.sv
// wb_arbiter -- writeback collector between execution units and the
// register file write side.
//
// Each of SOURCES producers hands results over a valid/ready handshake into
// its own DEPTH-entry FIFO. Every cycle up to WRITER FIFO heads are granted
// round-robin (scan starts at rr_ptr) and loaded into the registered write
// stage. A head whose address matches an address already granted in the
// same cycle is skipped, so one cycle never writes the same register twice.
// Results addressed to register 0 are accepted and then discarded.
//
// Optional feature macro: WB_ARBITER_FEEDBACK_EN
//   defined   : feedback_addr/data[k] mirror write_addr/data[k] for k < WRITER.
//               Ports at k >= WRITER drive 0.
//   undefined : feedback_* tied to 0. There is no bypass, so the issue logic
//               must stall one cycle on a same-cycle read.
//
// Ports
//   clk, rst                 clock; synchronous active-high reset
//   src_valid/ready[S]       per-source handshake
//   src_addr[S], src_data[S] destination register and result value
//   write_addr/data[W]       registered write stage, addr 0 = no write
//   feedback_addr/data[F]    bypass copy of the write stage, addr 0 = unused
//   busy                     any entry buffered or in the write stage
module wb_arbiter #(
    parameter int SOURCES  = 3,
    parameter int WRITER   = 1,
    parameter int FEEDBACK = 2,
    parameter int DEPTH    = 2,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [SOURCES-1:0]                 src_valid,
    output logic [SOURCES-1:0]                 src_ready,
    input  logic [SOURCES-1:0][ADDR_W-1:0]     src_addr,
    input  logic [SOURCES-1:0][DATA_W-1:0]     src_data,
    output logic [WRITER-1:0][ADDR_W-1:0]      write_addr,
    output logic [WRITER-1:0][DATA_W-1:0]      write_data,
    output logic [FEEDBACK-1:0][ADDR_W-1:0]    feedback_addr,
    output logic [FEEDBACK-1:0][DATA_W-1:0]    feedback_data,
    output logic                               busy
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int RW = (SOURCES > 1) ? $clog2(SOURCES) : 1;

    logic [SOURCES-1:0][DEPTH-1:0][ADDR_W-1:0] mem_addr;
    logic [SOURCES-1:0][DEPTH-1:0][DATA_W-1:0] mem_data;
    logic [SOURCES-1:0][PW-1:0]                rd_ptr, wr_ptr;
    logic [SOURCES-1:0][CW-1:0]                count, count_next;
    logic [SOURCES-1:0][ADDR_W-1:0]            head_addr;
    logic [SOURCES-1:0][DATA_W-1:0]            head_data;
    logic [SOURCES-1:0]                        push, gnt;
    logic [RW-1:0]                             rr_ptr, rr_next;
    logic [WRITER-1:0][ADDR_W-1:0]             nxt_addr;
    logic [WRITER-1:0][DATA_W-1:0]             nxt_data;
    logic                                      busy_next;

    // grant-scan scratch
    int   n_gnt, pos, last;
    logic hit;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // src_ready comes from the count flops only, so a pop from a full FIFO
    // opens the slot one cycle later.
    always_comb begin
        for (int s = 0; s < SOURCES; s++) begin
            src_ready[s] = (count[s] != CW'(DEPTH));
            push[s]      = src_valid[s] && src_ready[s] && (src_addr[s] != '0);
            head_addr[s] = mem_addr[s][rd_ptr[s]];
            head_data[s] = mem_data[s][rd_ptr[s]];
        end
    end

    // Round-robin scan from rr_ptr. The outer loop walks scan order; the
    // inner loop picks the matching source so all indices stay constant.
    always_comb begin
        gnt      = '0;
        nxt_addr = '0;
        nxt_data = '0;
        n_gnt    = 0;
        last     = -1;
        pos      = 0;
        hit      = 1'b0;
        for (int k = 0; k < SOURCES; k++) begin
            pos = int'(rr_ptr) + k;
            if (pos >= SOURCES) pos = pos - SOURCES;
            for (int s = 0; s < SOURCES; s++) begin
                if (s == pos && count[s] != '0 && n_gnt < WRITER) begin
                    hit = 1'b0;
                    for (int p = 0; p < WRITER; p++)
                        if (p < n_gnt && nxt_addr[p] == head_addr[s]) hit = 1'b1;
                    if (!hit) begin
                        gnt[s] = 1'b1;
                        for (int p = 0; p < WRITER; p++) begin
                            if (p == n_gnt) begin
                                nxt_addr[p] = head_addr[s];
                                nxt_data[p] = head_data[s];
                            end
                        end
                        n_gnt = n_gnt + 1;
                        last  = s;
                    end
                end
            end
        end
        rr_next = (last < 0) ? rr_ptr : RW'((last + 1) % SOURCES);
    end

    always_comb begin
        busy_next = 1'b0;
        for (int s = 0; s < SOURCES; s++) begin
            count_next[s] = count[s] + CW'(push[s]) - CW'(gnt[s]);
            if (count_next[s] != '0) busy_next = 1'b1;
        end
        for (int p = 0; p < WRITER; p++)
            if (nxt_addr[p] != '0) busy_next = 1'b1;
    end

    // FIFO storage carries no reset; validity lives in the counters.
    always_ff @(posedge clk) begin
        for (int s = 0; s < SOURCES; s++) begin
            if (push[s]) begin
                mem_addr[s][wr_ptr[s]] <= src_addr[s];
                mem_data[s][wr_ptr[s]] <= src_data[s];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            rr_ptr     <= '0;
            write_addr <= '0;
            write_data <= '0;
            busy       <= 1'b0;
        end else begin
            for (int s = 0; s < SOURCES; s++) begin
                if (push[s]) wr_ptr[s] <= bump(wr_ptr[s]);
                if (gnt[s])  rd_ptr[s] <= bump(rd_ptr[s]);
            end
            count      <= count_next;
            rr_ptr     <= rr_next;
            write_addr <= nxt_addr;
            write_data <= nxt_data;
            busy       <= busy_next;
        end
    end

`ifdef WB_ARBITER_FEEDBACK_EN
    logic [FEEDBACK-1:0][ADDR_W-1:0] fb_addr_next;
    logic [FEEDBACK-1:0][DATA_W-1:0] fb_data_next;

    always_comb begin
        fb_addr_next = '0;
        fb_data_next = '0;
        for (int p = 0; p < WRITER; p++) begin
            fb_addr_next[p] = nxt_addr[p];
            fb_data_next[p] = nxt_data[p];
        end
    end

    // Separate flops carrying the same values as the write stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            feedback_addr <= '0;
            feedback_data <= '0;
        end else begin
            feedback_addr <= fb_addr_next;
            feedback_data <= fb_data_next;
        end
    end
`else
    assign feedback_addr = '0;
    assign feedback_data = '0;
`endif

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback collector sitting between the execution units and the register file write side. Accepts completed results from `SOURCES` functional units over valid/ready handshakes and buffers them per source. It grants up to `WRITER` results per cycle round-robin and drives them registered onto the register file `write_addr`/`write_data` ports. The same values are mirrored onto the `feedback_addr`/`feedback_data` ports, so reads issued in the write cycle see the new value.

## Interface
- `SOURCES`, 3: number of producing units (≥1)
- `WRITER`, 1: register file write ports driven (1..SOURCES)
- `FEEDBACK`, 2: register file feedback ports driven (≥WRITER)
- `DEPTH`, 2: entries per source FIFO (power of two, ≥1)

- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `src_valid[SOURCES]`  in  1  source holds a result
- `src_ready[SOURCES]`  out  1  source FIFO can accept
- `src_addr[SOURCES]`  in  `reg_idx`  destination register
- `src_data[SOURCES]`  in  `gpreg`  result value
- `write_addr[WRITER]`  out  `reg_idx`  register file write address, 0 = no write
- `write_data[WRITER]`  out  `gpreg`  register file write data
- `feedback_addr[FEEDBACK]`  out  `reg_idx`  bypass address, 0 = unused
- `feedback_data[FEEDBACK]`  out  `gpreg`  bypass data
- `busy`  out  1  any entry buffered or in the write stage

## Operation
- Handshake: transfer when `src_valid[i] && src_ready[i]` at a rising edge. `src_ready[i]` = FIFO i not full. It does not depend on `src_valid`.
- Results with `src_addr == 0` complete the handshake but are discarded. They use no FIFO entry and no write slot.
- Per-source FIFO order is preserved. No ordering is guaranteed across sources.
- Grant, combinational each cycle:
  - Scan sources starting at `rr_ptr`, wrapping mod `SOURCES`.
  - Grant each non-empty head until `WRITER` grants are made.
  - Skip any head whose address equals an address already granted this cycle. The skipped head stays for a later cycle.
  - Grant n goes to write port n, in scan order.
- At the edge, granted heads are popped and loaded into the write-stage registers. Unused ports load addr 0, data 0.
- `rr_ptr` becomes (last granted source + 1) mod `SOURCES`. If there are no grants, `rr_ptr` holds.
- Empty FIFOs never block other sources. A source pushing and being granted in the same cycle is legal. A pop from a full FIFO frees space for the following cycle only, because `src_ready` is not combinationally dependent on the pop.
- `busy` = any FIFO non-empty OR any `write_addr` ≠ 0.
- Reset: FIFOs empty, `rr_ptr` = 0, all `write_*`/`feedback_*` = 0, `busy` = 0, `src_ready` = 1 on the cycle after reset.
- Reset asserted mid-operation drops all buffered and in-flight results. Nothing is written after the reset edge.

## Timing
- Result accepted at edge t is granted at edge t+1 at the earliest. It is then visible on `write_*`/`feedback_*` during cycle t+1..t+2 and committed to storage at edge t+2.
- Worst-case wait with all FIFOs full: ceil(SOURCES/WRITER) cycles per entry ahead of it.
- All outputs except `src_ready` are flop outputs. `src_ready` comes from FIFO count flops only.
- Throughput: `WRITER` results per cycle when no two heads share an address.

## Configuration
- `WB_ARBITER_FEEDBACK_EN` defined:
  - `feedback_addr[k]`/`feedback_data[k]` mirror `write_addr[k]`/`write_data[k]` for k < `WRITER`.
  - Ports k ≥ `WRITER` drive 0/0.
- `WB_ARBITER_FEEDBACK_EN` undefined:
  - All `feedback_*` are tied to 0, so there is no bypass.
  - The register file returns the old value for same-cycle reads. The issue logic must stall one cycle instead.

## Test plan
- Reset, then source 0 pushes addr 5, data 0xDEADBEEF → `write_addr[0]`=5, `write_data[0]`=0xDEADBEEF one cycle after acceptance, for one cycle. With the macro defined, `feedback_addr[0]`=5 in the same cycle. Then all outputs return to 0 and `busy` falls.
- SOURCES=3, WRITER=1: all sources push continuously (addrs 1/2/3) → write port cycles 1,2,3,1,2,3. No FIFO starves. `src_ready` toggles correctly when FIFOs fill at DEPTH=2.
- Push addr 0 with data 0x1234 → handshake completes, `write_addr` stays 0, `busy` stays 0.
- WRITER=2: sources 0 and 1 both hold heads to addr 7 (data 0xA, 0xB), `rr_ptr`=0 → cycle 1 writes 7=0xA on port 0 with port 1 idle. Cycle 2 writes 7=0xB.
- Fill source 2 FIFO (2 entries) and assert `rst` before drain → every `write_addr` is 0 from the cycle after reset, and `busy`=0.
- Macro undefined: repeat the first scenario → `feedback_addr[*]` remain 0 throughout.
